// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave.
// State encoding for the frame FSM and the two-bit command field values.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

  // True for the states that shift in the body of a frame.
  function automatic logic is_data_state(state_t s);
    return (s == WRITE) || (s == READ_ADD) || (s == READ_DATA);
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus the parallel rx/tx side of the slave.
// frame_err exists only when SPI_SLAVE_FRAME_ERR_EN is defined.
interface spi_slave_if #(
  parameter int unsigned ADDR_SIZE = 8
);
  logic                 SS_n;
  logic                 MOSI;
  logic                 MISO;
  logic [ADDR_SIZE+1:0] rx_data;
  logic                 rx_valid;
  logic [ADDR_SIZE-1:0] tx_data;
  logic                 tx_valid;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic                 frame_err;
`endif

`ifdef SPI_SLAVE_FRAME_ERR_EN
  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, frame_err
  );
  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, frame_err
  );
`else
  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );
  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
`endif

endinterface

// File: rtl/spi_miso_shifter.sv
// spi_miso_shifter: parallel-load, MSB-first shift register feeding MISO.
module spi_miso_shifter #(
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 shift,
  input  logic [ADDR_SIZE-1:0] din,
  output logic                 dout
);

  logic [ADDR_SIZE-1:0] sr;

  // Load has priority over shift; zeros fill from the bottom.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[ADDR_SIZE-2:0], 1'b0};
    end
  end

  assign dout = sr[ADDR_SIZE-1];

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI slave sampling SS_n/MOSI on clk, framing ADDR_SIZE+2 bits
// (2-bit command + payload) and returning a read word on MISO.
// Optional feature macro: SPI_SLAVE_FRAME_ERR_EN adds the frame_err pulse.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 8
) (
  input logic        clk,
  input logic        rst,
  spi_slave_if.slave bus
);

  localparam int unsigned FRAME_W = ADDR_SIZE + 2;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
  localparam int unsigned TXC_W   = $clog2(ADDR_SIZE + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
  localparam logic [TXC_W-1:0] LAST_TX  = TXC_W'(ADDR_SIZE - 1);

  state_t               state, state_nxt;
  logic                 rd_addr_seen;
  logic                 frame_done;
  logic                 tx_loaded;
  logic                 tx_active;
  logic [CNT_W-1:0]     bit_cnt;
  logic [TXC_W-1:0]     tx_cnt;
  logic [FRAME_W-2:0]   rx_shreg;

  logic                 in_data;
  logic                 abort;
  logic                 capture_last;
  logic                 tx_load;
  logic                 tx_shift;
  logic                 sh_load;
  logic [ADDR_SIZE-1:0] sh_din;
  logic                 sh_dout;

  assign in_data      = is_data_state(state);
  assign abort        = (state != IDLE) && bus.SS_n;
  // The final bit is taken even if SS_n rises on the same sample.
  assign capture_last = in_data && !frame_done && (bit_cnt == LAST_BIT);
  assign tx_load      = (state == READ_DATA) && frame_done && !tx_loaded &&
                        bus.tx_valid && !bus.SS_n;
  assign tx_shift     = (state == READ_DATA) && tx_active && !bus.SS_n;

  // Clearing the shifter on deselect reuses the parallel load with zero data.
  assign sh_load = abort || tx_load;
  assign sh_din  = abort ? '0 : bus.tx_data;

  spi_miso_shifter #(.ADDR_SIZE(ADDR_SIZE)) u_miso_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (sh_load),
    .shift (tx_shift),
    .din   (sh_din),
    .dout  (sh_dout)
  );

  assign bus.MISO = tx_active & sh_dout;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; deselect overrides everything outside IDLE.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (!bus.SS_n) state_nxt = CHK_CMD;
        CHK_CMD: begin
          if (!bus.MOSI)        state_nxt = WRITE;
          else if (rd_addr_seen) state_nxt = READ_DATA;
          else                   state_nxt = READ_ADD;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Frame capture, rx handshake, read-word sequencing and rd_addr_seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      rd_addr_seen <= 1'b0;
      frame_done   <= 1'b0;
      tx_loaded    <= 1'b0;
      tx_active    <= 1'b0;
      bit_cnt      <= '0;
      tx_cnt       <= '0;
      rx_shreg     <= '0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      bus.frame_err <= 1'b0;
`endif
    end else begin
      bus.rx_valid <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      bus.frame_err <= 1'b0;
`endif
      if (capture_last) begin
        bus.rx_data  <= {rx_shreg, bus.MOSI};
        bus.rx_valid <= 1'b1;
        frame_done   <= 1'b1;
        if (state == READ_ADD) rd_addr_seen <= 1'b1;
      end

      if (abort) begin
        bit_cnt    <= '0;
        tx_cnt     <= '0;
        frame_done <= 1'b0;
        tx_loaded  <= 1'b0;
        tx_active  <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        if (!frame_done && !capture_last) bus.frame_err <= 1'b1;
`endif
      end else begin
        if (state == CHK_CMD) begin
          rx_shreg <= {rx_shreg[FRAME_W-3:0], bus.MOSI};
          bit_cnt  <= CNT_W'(1);
        end else if (in_data && !frame_done && !capture_last) begin
          rx_shreg <= {rx_shreg[FRAME_W-3:0], bus.MOSI};
          bit_cnt  <= bit_cnt + CNT_W'(1);
        end

        if (tx_load) begin
          tx_loaded <= 1'b1;
          tx_active <= 1'b1;
          tx_cnt    <= '0;
        end else if (tx_shift) begin
          tx_cnt <= tx_cnt + TXC_W'(1);
          if (tx_cnt == LAST_TX) begin
            tx_active    <= 1'b0;
            rd_addr_seen <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed self-checking bench for spi_slave.
module tb_spi_slave;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_slave_if #(.ADDR_SIZE(8)) bus ();

  spi_slave #(.ADDR_SIZE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame;
    bus.SS_n = 1'b0;
    tick();
  endtask

  task automatic send_bits(input logic [9:0] f, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      bus.MOSI = f[i];
      tick();
    end
  endtask

  task automatic end_frame;
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.SS_n = 1'b1; bus.MOSI = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0;
    #12;
    tests++; if (bus.MISO !== 1'b0) begin fails++; $display("FAIL rst_miso: got %b want 0", bus.MISO); end
    tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL rst_rx_valid: got %b want 0", bus.rx_valid); end
    tests++; if (bus.rx_data !== 10'h000) begin fails++; $display("FAIL rst_rx_data: got %h want 000", bus.rx_data); end
    tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL rst_state: got %0d want IDLE", dut.state); end
    tests++; if (dut.rd_addr_seen !== 1'b0) begin fails++; $display("FAIL rst_seen: got %b want 0", dut.rd_addr_seen); end
`ifdef SPI_SLAVE_FRAME_ERR_EN
    tests++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL rst_ferr: got %b want 0", bus.frame_err); end
`endif
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_addr;
    start_frame();
    send_bits({WR_ADDR, 8'hA5}, 9, 0);
    tests++; if (bus.rx_valid !== 1'b1) begin fails++; $display("FAIL wa_valid: got %b want 1", bus.rx_valid); end
    tests++; if (bus.rx_data !== 10'h0A5) begin fails++; $display("FAIL wa_data: got %h want 0a5", bus.rx_data); end
    for (int i = 0; i < 4; i++) begin
      bus.MOSI = ~bus.MOSI;
      tick();
      tests++;
      if (bus.rx_valid !== 1'b0 || dut.state !== WRITE) begin
        fails++; $display("FAIL wa_hold%0d: valid %b state %0d want 0/WRITE", i, bus.rx_valid, dut.state);
      end
    end
    end_frame();
    tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL wa_idle: got %0d want IDLE", dut.state); end
  endtask

  task automatic test_write_data;
    start_frame();
    send_bits({WR_DATA, 8'h3C}, 9, 0);
    tests++; if (bus.rx_valid !== 1'b1) begin fails++; $display("FAIL wd_valid: got %b want 1", bus.rx_valid); end
    tests++; if (bus.rx_data !== 10'h13C) begin fails++; $display("FAIL wd_data: got %h want 13c", bus.rx_data); end
    end_frame();
    tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL wd_pulse: got %b want 0", bus.rx_valid); end
  endtask

  task automatic test_read;
    logic [7:0] word;
    word = 8'hC3;
    start_frame();
    send_bits({RD_ADDR, 8'hF0}, 9, 0);
    tests++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 10'h2F0) begin fails++; $display("FAIL ra_frame: valid %b data %h want 1/2f0", bus.rx_valid, bus.rx_data); end
    tests++; if (dut.state !== READ_ADD) begin fails++; $display("FAIL ra_state: got %0d want READ_ADD", dut.state); end
    end_frame();
    tests++; if (dut.rd_addr_seen !== 1'b1) begin fails++; $display("FAIL ra_seen: got %b want 1", dut.rd_addr_seen); end
    start_frame();
    send_bits({RD_DATA, 8'hFF}, 9, 0);
    tests++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 10'h3FF) begin fails++; $display("FAIL rd_frame: valid %b data %h want 1/3ff", bus.rx_valid, bus.rx_data); end
    tests++; if (dut.state !== READ_DATA) begin fails++; $display("FAIL rd_state: got %0d want READ_DATA", dut.state); end
    tests++; if (bus.MISO !== 1'b0) begin fails++; $display("FAIL rd_miso_idle: got %b want 0", bus.MISO); end
    tick();
    tick();
    bus.tx_valid = 1'b1; bus.tx_data = word;
    tick();
    bus.tx_valid = 1'b0; bus.tx_data = '0;
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (bus.MISO !== word[7-k]) begin fails++; $display("FAIL rd_miso_b%0d: got %b want %b", k, bus.MISO, word[7-k]); end
      bus.tx_valid = (k == 3);
      tick();
    end
    bus.tx_valid = 1'b0;
    tests++; if (bus.MISO !== 1'b0) begin fails++; $display("FAIL rd_miso_done: got %b want 0", bus.MISO); end
    tests++; if (dut.rd_addr_seen !== 1'b0) begin fails++; $display("FAIL rd_seen_clr: got %b want 0", dut.rd_addr_seen); end
    tick();
    tests++; if (bus.MISO !== 1'b0) begin fails++; $display("FAIL rd_miso_reload: got %b want 0", bus.MISO); end
    end_frame();
  endtask

  task automatic test_abort;
    logic any_valid;
    any_valid = 1'b0;
    start_frame();
    for (int i = 9; i >= 4; i--) begin
      bus.MOSI = (i % 2 == 1);
      tick();
      any_valid = any_valid | bus.rx_valid;
    end
    bus.SS_n = 1'b1;
    tick();
    any_valid = any_valid | bus.rx_valid;
    tests++; if (any_valid !== 1'b0) begin fails++; $display("FAIL ab_valid: got %b want 0", any_valid); end
    tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL ab_state: got %0d want IDLE", dut.state); end
    tests++; if (dut.rd_addr_seen !== 1'b0) begin fails++; $display("FAIL ab_seen: got %b want 0", dut.rd_addr_seen); end
`ifdef SPI_SLAVE_FRAME_ERR_EN
    tests++; if (bus.frame_err !== 1'b1) begin fails++; $display("FAIL ab_ferr: got %b want 1", bus.frame_err); end
    tick();
    tests++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL ab_ferr_pulse: got %b want 0", bus.frame_err); end
`endif
    start_frame();
    send_bits(10'h0C3, 9, 0);
    tests++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 10'h0C3) begin fails++; $display("FAIL ab_next: valid %b data %h want 1/0c3", bus.rx_valid, bus.rx_data); end
    end_frame();
  endtask

  task automatic test_ss_high_last;
    start_frame();
    send_bits(10'h155, 9, 1);
    bus.MOSI = 1'b1;
    bus.SS_n = 1'b1;
    tick();
    tests++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 10'h155) begin fails++; $display("FAIL sl_frame: valid %b data %h want 1/155", bus.rx_valid, bus.rx_data); end
    tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL sl_state: got %0d want IDLE", dut.state); end
`ifdef SPI_SLAVE_FRAME_ERR_EN
    tests++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL sl_ferr: got %b want 0", bus.frame_err); end
`endif
    tick();
    tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL sl_pulse: got %b want 0", bus.rx_valid); end
  endtask

  task automatic test_wait_no_tx;
    start_frame();
    send_bits(10'h2F0, 9, 0);
    end_frame();
    start_frame();
    send_bits(10'h3A5, 9, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (bus.MISO !== 1'b0 || dut.state !== READ_DATA) begin
        fails++; $display("FAIL nt_hold%0d: miso %b state %0d want 0/READ_DATA", i, bus.MISO, dut.state);
      end
    end
    end_frame();
    tests++; if (dut.rd_addr_seen !== 1'b1 || dut.state !== IDLE) begin fails++; $display("FAIL nt_exit: seen %b state %0d want 1/IDLE", dut.rd_addr_seen, dut.state); end
  endtask

  task automatic test_reset_mid_read;
    start_frame();
    send_bits(10'h3FF, 9, 0);
    tests++; if (dut.state !== READ_DATA) begin fails++; $display("FAIL rr_state: got %0d want READ_DATA", dut.state); end
    bus.tx_valid = 1'b1; bus.tx_data = 8'hFF;
    tick();
    bus.tx_valid = 1'b0; bus.tx_data = '0;
    tick(); tick(); tick();
    tests++; if (bus.MISO !== 1'b1) begin fails++; $display("FAIL rr_bit4: got %b want 1", bus.MISO); end
    #2 rst = 1'b1;
    #1;
    tests++; if (bus.MISO !== 1'b0) begin fails++; $display("FAIL rr_miso: got %b want 0", bus.MISO); end
    tests++; if (dut.state !== IDLE || dut.rd_addr_seen !== 1'b0) begin fails++; $display("FAIL rr_clear: state %0d seen %b want IDLE/0", dut.state, dut.rd_addr_seen); end
    tests++; if (bus.rx_data !== 10'h000) begin fails++; $display("FAIL rr_rx_data: got %h want 000", bus.rx_data); end
    bus.SS_n = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    start_frame();
    bus.MOSI = 1'b1;
    tick();
    tests++; if (dut.state !== READ_ADD) begin fails++; $display("FAIL rr_decode: got %0d want READ_ADD", dut.state); end
    send_bits(10'h2AA, 8, 0);
    tests++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 10'h2AA) begin fails++; $display("FAIL rr_frame: valid %b data %h want 1/2aa", bus.rx_valid, bus.rx_data); end
    end_frame();
    tests++; if (dut.rd_addr_seen !== 1'b1) begin fails++; $display("FAIL rr_seen: got %b want 1", dut.rd_addr_seen); end
  endtask

  initial begin
    test_reset();
    test_write_addr();
    test_write_data();
    test_read();
    test_abort();
    test_ss_high_last();
    test_wait_no_tx();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 8, giving the payload width; frame width is ADDR_SIZE+2.
REQ-002 SHALL have port clk, input, 1, the single clock; SPI bits are sampled on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port SS_n, input, 1, slave select, active-low.
REQ-005 SHALL have port MOSI, input, 1, serial data in, MSB first.
REQ-006 SHALL have port MISO, output, 1, serial read data out, MSB first.
REQ-007 SHALL have port rx_data, output, ADDR_SIZE+2, received frame; [9:8] is the command and [7:0] is the payload.
REQ-008 SHALL have port rx_valid, output, 1, one-cycle pulse qualifying rx_data.
REQ-009 SHALL have port tx_data, input, ADDR_SIZE, memory read word.
REQ-010 SHALL have port tx_valid, input, 1, qualifies tx_data.

Function
REQ-011 SHALL implement states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-012 IDLE: on the first cycle SS_n is sampled low, SHALL go to CHK_CMD; no bit is captured.
REQ-013 CHK_CMD: SHALL capture MOSI as frame bit 9, then go to:
  - WRITE if the bit is 0;
  - READ_ADD if the bit is 1 and rd_addr_seen=0;
  - READ_DATA if the bit is 1 and rd_addr_seen=1.
REQ-014 WRITE/READ_ADD/READ_DATA SHALL shift in the remaining 9 bits, one per cycle, using a bit counter.
REQ-015 rx_data SHALL update, and rx_valid SHALL pulse high for exactly one cycle, in the cycle after the 10th bit is captured.
REQ-016 READ_ADD SHALL set rd_addr_seen when its frame completes.
REQ-017 After frame completion, WRITE/READ_ADD SHALL ignore MOSI until SS_n is high.
REQ-018 READ_DATA, after its rx_valid, SHALL wait for tx_valid=1 and load tx_data into the MISO shifter.
  - Starting the next cycle, it SHALL drive the 8 bits MSB-first, one per cycle.
  - rd_addr_seen SHALL clear after the 8th bit.
REQ-019 MISO SHALL be 0 whenever no read bit is being driven.
REQ-020 tx_valid SHALL be ignored outside READ_DATA and after the load.
REQ-021 SS_n sampled high in any state SHALL force IDLE on the next edge.
  - The bit counter and MISO shifter clear.
  - No rx_valid is issued for a partial frame.
  - rd_addr_seen is unchanged.
REQ-022 SS_n high and frame completion in the same cycle: the completed frame SHALL still produce rx_valid.
REQ-023 A read-data frame with no tx_valid SHALL hold in READ_DATA, MISO=0, until SS_n is high.

Reset
REQ-024 rst=1 SHALL asynchronously set:
  - state=IDLE;
  - rx_data=0, rx_valid=0, MISO=0;
  - rd_addr_seen=0;
  - counter=0, shifter=0.
REQ-025 Reset mid-frame SHALL discard the frame; the first frame after release SHALL be decoded as if rd_addr_seen=0.

Configuration
REQ-026 With macro SPI_SLAVE_FRAME_ERR_EN defined:
  - the block SHALL add output frame_err, 1 bit;
  - frame_err SHALL pulse one cycle when SS_n rises before a frame's 10th bit;
  - frame_err is 0 in reset.
REQ-027 Without SPI_SLAVE_FRAME_ERR_EN, frame_err and its logic SHALL be absent; behaviour is otherwise identical.

Structure
REQ-028 Package spi_pkg SHALL hold:
  - the state encoding type;
  - command constants WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11.
REQ-029 The MISO parallel-load shift register SHALL be sub-module spi_miso_shifter, with ports load, shift, din[ADDR_SIZE-1:0] and dout.

Verification
REQ-030 Write address: SS_n low, MOSI 10'b00_1010_0101 -> exactly one rx_valid with rx_data=10'h0A5; state WRITE until SS_n is high.
REQ-031 Write data: frame 10'b01_0011_1100 -> rx_valid with rx_data=10'h13C.
REQ-032 Read sequence: frame 10'h2F0 -> rx_data=10'h2F0 and rd_addr_seen=1.
  - Then frame 10'h3FF -> rx_valid; tx_valid with tx_data=8'hC3 two cycles later.
  - MISO then emits 1,1,0,0,0,0,1,1 on consecutive cycles and rd_addr_seen=0.
REQ-033 Abort: SS_n high after 6 bits -> no rx_valid, IDLE next cycle; with SPI_SLAVE_FRAME_ERR_EN, one frame_err pulse.
REQ-034 Reset mid-read: assert rst during the 4th MISO bit -> MISO=0 immediately, IDLE; the next frame starting with 1 goes to READ_ADD.
